// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: multiplexed 8-digit display scanner.
// Each digit gets a DEAD-cycle blanking phase followed by a DIV-cycle show
// phase. The digit code and its mask flag are captured when the show phase
// starts, so input changes mid-show have no visible effect.
// Optional build macro: LEADING_ZERO_BLANK_EN also darkens leading zeros
// (digit 0 always stays lit).
module display_scan_ctrl #(
  parameter int unsigned DIV  = 1000,
  parameter int unsigned DEAD = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [31:0] digits,
  input  logic [7:0]  blank_mask,
  output logic [2:0]  sel,
  output logic        dec_en,
  output logic [3:0]  bcd_out,
  output logic        frame_tick
);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [15:0] DIV_LAST  = 16'(DIV - 1);
  localparam logic [15:0] DEAD_LAST = 16'(DEAD - 1);

  state_t      state_r, nxt_state_s;
  logic [15:0] cnt_r, nxt_cnt_s;
  logic [2:0]  sel_r, nxt_sel_s;
  logic [3:0]  bcd_r, nxt_bcd_s;
  logic        mask_r, nxt_mask_s;
  logic        tick_r, nxt_tick_s;
  logic        dec_en_r, nxt_dec_en_s;
  logic        entry_mask_s;

`ifdef LEADING_ZERO_BLANK_EN
  // True when s is not digit 0 and every digit from s up to 7 is zero.
  function automatic logic lead_zero(input logic [31:0] d, input logic [2:0] s);
    logic nz;
    nz = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k >= int'(s) && d[4*k +: 4] != 4'd0) begin
        nz = 1'b1;
      end else begin
        nz = nz;
      end
    end
    return (s != 3'd0) && !nz;
  endfunction

  // Mask flag to capture at show entry: explicit mask or leading zero.
  always_comb begin
    entry_mask_s = blank_mask[sel_r] | lead_zero(digits, sel_r);
  end
`else
  // Mask flag to capture at show entry: explicit mask only.
  always_comb begin
    entry_mask_s = blank_mask[sel_r];
  end
`endif

  // Next-state, phase counter, scan position and captured digit.
  always_comb begin
    nxt_state_s = state_r;
    nxt_cnt_s   = cnt_r;
    nxt_sel_s   = sel_r;
    nxt_bcd_s   = bcd_r;
    nxt_mask_s  = mask_r;
    nxt_tick_s  = 1'b0;
    if (!run) begin
      // Stop: go dark, hold position, restart the blanking phase later.
      nxt_state_s = BLANK;
      nxt_cnt_s   = 16'd0;
    end else begin
      case (state_r)
        BLANK: begin
          if (cnt_r == DEAD_LAST) begin
            nxt_state_s = SHOW;
            nxt_cnt_s   = 16'd0;
            nxt_bcd_s   = digits[{sel_r, 2'b00} +: 4];
            nxt_mask_s  = entry_mask_s;
          end else begin
            nxt_cnt_s = cnt_r + 16'd1;
          end
        end
        SHOW: begin
          if (cnt_r == DIV_LAST) begin
            nxt_state_s = BLANK;
            nxt_cnt_s   = 16'd0;
            nxt_sel_s   = sel_r + 3'd1;
            nxt_tick_s  = (sel_r == 3'd7);
          end else begin
            nxt_cnt_s = cnt_r + 16'd1;
          end
        end
        default: begin
          nxt_state_s = BLANK;
          nxt_cnt_s   = 16'd0;
        end
      endcase
    end
    nxt_dec_en_s = (nxt_state_s == SHOW) && !nxt_mask_s;
  end

  // State and output registers; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= BLANK;
      cnt_r    <= 16'd0;
      sel_r    <= 3'd0;
      bcd_r    <= 4'd0;
      mask_r   <= 1'b0;
      tick_r   <= 1'b0;
      dec_en_r <= 1'b0;
    end else begin
      state_r  <= nxt_state_s;
      cnt_r    <= nxt_cnt_s;
      sel_r    <= nxt_sel_s;
      bcd_r    <= nxt_bcd_s;
      mask_r   <= nxt_mask_s;
      tick_r   <= nxt_tick_s;
      dec_en_r <= nxt_dec_en_s;
    end
  end

  assign sel        = sel_r;
  assign dec_en     = dec_en_r;
  assign bcd_out    = bcd_r;
  assign frame_tick = tick_r;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl (DIV=4, DEAD=2): directed timing checks
// plus randomized run/rst/digit/mask traffic against a window-age model.
module tb_display_scan_ctrl;

  localparam int DIV  = 4;
  localparam int DEAD = 2;
  localparam int WIN  = DIV + DEAD;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [31:0] digits;
  logic [7:0]  blank_mask;
  logic [2:0]  sel;
  logic        dec_en;
  logic [3:0]  bcd_out;
  logic        frame_tick;

  int total = 0;
  int bad   = 0;

  // Model: position, age of the current cycle inside its digit window,
  // values captured when the show part of the window began.
  int   m_sel, m_age, m_bcd;
  logic m_mask, m_tick;

  display_scan_ctrl #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .run(run), .digits(digits), .blank_mask(blank_mask),
    .sel(sel), .dec_en(dec_en), .bcd_out(bcd_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic model_mask(input logic [31:0] d, input logic [7:0] m, input int s);
    logic f;
    f = m[s];
`ifdef LEADING_ZERO_BLANK_EN
    if (s != 0 && (d >> (4 * s)) == 32'd0) f = 1'b1;
`endif
    return f;
  endfunction

  // One clock: advance the model with the inputs present at the edge,
  // then compare all outputs shortly after.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_sel = 0; m_age = 0; m_bcd = 0; m_mask = 1'b0; m_tick = 1'b0;
    end else if (!run) begin
      m_age = 0; m_tick = 1'b0;
    end else begin
      m_tick = 1'b0;
      m_age  = m_age + 1;
      if (m_age == WIN) begin
        m_age  = 0;
        m_sel  = (m_sel + 1) % 8;
        m_tick = (m_sel == 0);
      end else if (m_age == DEAD) begin
        m_bcd  = (digits >> (4 * m_sel)) & 32'hF;
        m_mask = model_mask(digits, blank_mask, m_sel);
      end
    end
    #1;
    check_eq("sel", 32'(sel), 32'(m_sel));
    check_eq("dec_en", 32'(dec_en), 32'((m_age >= DEAD) && !m_mask));
    check_eq("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check_eq("frame_tick", 32'(frame_tick), 32'(m_tick));
  endtask

  task automatic wait_show2(input int s);
    int n;
    n = 0;
    while (!(m_sel == s && m_age == DEAD + 1) && n < 200) begin
      step();
      n++;
    end
    check_eq("wait_show2_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    logic [11:0] en_hist;
    int ticks;
    logic [31:0] r;

    rst = 1'b1; run = 1'b1; digits = 32'h76543210; blank_mask = 8'h00;
    step(); step();
    check_eq("reset_dec_en", 32'(dec_en), 32'd0);
    check_eq("reset_sel", 32'(sel), 32'd0);

    // Cycle 0 is the current cycle; dec_en must be high in 2-5 and 8-11.
    rst = 1'b0;
    en_hist = 12'd0;
    en_hist[0] = dec_en;
    for (int i = 1; i < 12; i++) begin
      step();
      en_hist[i] = dec_en;
      if (dec_en) check_eq("bcd_eq_sel", 32'(bcd_out), 32'(sel));
    end
    check_eq("first_enable_pattern", 32'(en_hist), 32'hF3C);
    ticks = 0;
    for (int i = 12; i <= 96; i++) begin
      step();
      if (frame_tick) ticks++;
      if (i == 48 || i == 96) check_eq("tick_at_frame", 32'(frame_tick), 32'd1);
    end
    check_eq("tick_count", 32'(ticks), 32'd2);

    // Masked digit 2 stays dark for its whole window.
    blank_mask = 8'b0000_0100;
    for (int i = 0; i < 60; i++) begin
      step();
      if (sel == 3'd2) check_eq("masked_dark", 32'(dec_en), 32'd0);
    end
    blank_mask = 8'h00;

    // Drop run in the second show cycle of digit 3.
    wait_show2(3);
    run = 1'b0;
    step();
    check_eq("run_drop_dark", 32'(dec_en), 32'd0);
    step(); step();
    check_eq("run_drop_sel", 32'(sel), 32'd3);
    run = 1'b1;
    step();
    check_eq("resume_blank1", 32'(dec_en), 32'd0);
    step();
    check_eq("resume_show", 32'(dec_en), 32'd1);
    check_eq("resume_sel", 32'(sel), 32'd3);
    for (int i = 0; i < 4; i++) step();

    // Digits changed mid-show do not reach bcd_out.
    wait_show2(5);
    digits = 32'h9999_9999;
    step();
    check_eq("midshow_hold", 32'(bcd_out), 32'd5);
    digits = 32'h76543210;

    // Reset in the middle of a show phase.
    wait_show2(6);
    rst = 1'b1;
    step();
    check_eq("midshow_rst", {28'd0, sel, dec_en, bcd_out, frame_tick}, 32'd0);
    rst = 1'b0;

    // Leading-zero stimulus: lit pattern depends on build option.
    digits = 32'h0000_0120;
    for (int i = 0; i < 2 * 8 * WIN; i++) step();
    digits = 32'h0;
    for (int i = 0; i < 8 * WIN + 4; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      run = ($urandom_range(0, 19) != 0);
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom();
        digits = ($urandom_range(0, 1) == 1) ? (r >> (4 * $urandom_range(0, 7))) : r;
      end
      if ($urandom_range(0, 15) == 0)
        blank_mask = ($urandom_range(0, 1) == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
